// File: rtl/mem_access_ctrl_if.sv
// RAM-side bus bundle for mem_access_ctrl: control request inputs, RAM strobe/data, and status.
// slave = the controller, master = whoever drives requests and models the RAM.
interface mem_access_ctrl_if;
   logic        ram_enable;
   logic        rw;
   logic [4:0]  mem_fnc;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        moc;
   logic [31:0] ram_rdata;
   logic        ram_strobe;
   logic        ram_rw;
   logic [31:0] ram_addr;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        done;
   logic        err_align;
   logic        err_timeout;

   modport slave (
      input  ram_enable, rw, mem_fnc, addr, wdata, moc, ram_rdata,
      output ram_strobe, ram_rw, ram_addr, ram_be, ram_wdata, rdata,
             stall, done, err_align, err_timeout
   );

   modport master (
      output ram_enable, rw, mem_fnc, addr, wdata, moc, ram_rdata,
      input  ram_strobe, ram_rw, ram_addr, ram_be, ram_wdata, rdata,
             stall, done, err_align, err_timeout
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: request decode, big-endian lane steering, MOC wait with timeout.
// Optional macro MOC_SYNC_EN inserts a 2-flop synchronizer on moc.
module mem_access_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   mem_access_ctrl_if.slave bus,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [4:0] F_LW  = 5'b01000;
   localparam logic [4:0] F_LHU = 5'b01001;
   localparam logic [4:0] F_LB  = 5'b01010;
   localparam logic [4:0] F_LH  = 5'b01011;
   localparam logic [4:0] F_LBU = 5'b01100;
   localparam logic [4:0] F_SW  = 5'b01101;
   localparam logic [4:0] F_SH  = 5'b01110;
   localparam logic [4:0] F_SB  = 5'b01111;

   // Handshake: a request is taken on any edge where IDLE sees ram_enable; the RAM
   // completes it by raising moc while ram_strobe is high; stall holds the pipeline meanwhile.
   state_t         state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           strobe_q, rw_q, done_q, err_align_q, err_timeout_q;
   logic [4:0]     fnc_q;
   logic [31:0]    addr_q, wdata_q, rdata_q;
   logic [3:0]     be_q;

   logic           moc_s;
   logic           req_legal, req_aligned;
   logic [3:0]     req_be;
   logic [31:0]    req_wdata;
   logic [7:0]     ld_byte;
   logic [15:0]    ld_half;
   logic [31:0]    ld_ext;

`ifdef MOC_SYNC_EN
   logic [1:0] moc_sync_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) moc_sync_q <= 2'b00;
      else          moc_sync_q <= {moc_sync_q[0], bus.moc};
   end
   assign moc_s = moc_sync_q[1];
`else
   assign moc_s = bus.moc;
`endif

   // Size is taken from the function code; rw alone decides load vs store.
   always_comb begin
      req_legal   = (bus.mem_fnc[4:3] == 2'b01);
      req_aligned = 1'b1;
      req_be      = 4'b1000 >> bus.addr[1:0];
      req_wdata   = {4{bus.wdata[7:0]}};
      case (bus.mem_fnc)
         F_LW, F_SW: begin
            req_aligned = (bus.addr[1:0] == 2'b00);
            req_be      = 4'b1111;
            req_wdata   = bus.wdata;
         end
         F_LHU, F_LH, F_SH: begin
            req_aligned = ~bus.addr[0];
            req_be      = bus.addr[1] ? 4'b0011 : 4'b1100;
            req_wdata   = {2{bus.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (addr_q[1:0])
         2'd0:    ld_byte = bus.ram_rdata[31:24];
         2'd1:    ld_byte = bus.ram_rdata[23:16];
         2'd2:    ld_byte = bus.ram_rdata[15:8];
         default: ld_byte = bus.ram_rdata[7:0];
      endcase
      ld_half = addr_q[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
      case (fnc_q)
         F_LB:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         F_LBU:   ld_ext = {24'd0, ld_byte};
         F_LH:    ld_ext = {{16{ld_half[15]}}, ld_half};
         F_LHU:   ld_ext = {16'd0, ld_half};
         F_SH:    ld_ext = {16'd0, ld_half};
         F_SB:    ld_ext = {24'd0, ld_byte};
         default: ld_ext = bus.ram_rdata;
      endcase
   end

   assign cnt_d = cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         strobe_q      <= 1'b0;
         rw_q          <= 1'b0;
         done_q        <= 1'b0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         fnc_q         <= 5'd0;
         addr_q        <= 32'd0;
         wdata_q       <= 32'd0;
         rdata_q       <= 32'd0;
         be_q          <= 4'd0;
      end else begin
         done_q        <= 1'b0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.ram_enable) begin
                  addr_q  <= bus.addr;
                  fnc_q   <= bus.mem_fnc;
                  rw_q    <= bus.rw;
                  be_q    <= req_be;
                  wdata_q <= req_wdata;
                  cnt_q   <= '0;
                  if (req_legal && req_aligned) begin
                     strobe_q <= 1'b1;
                     state_q  <= S_WAIT;
                  end else begin
                     err_align_q <= 1'b1;
                     state_q     <= S_ERR;
                  end
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_d;
               // Completion outranks a timeout landing on the same edge.
               if (moc_s) begin
                  strobe_q <= 1'b0;
                  done_q   <= 1'b1;
                  if (rw_q) rdata_q <= ld_ext;
                  state_q  <= S_DONE;
               end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                  strobe_q      <= 1'b0;
                  err_timeout_q <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end
            S_DONE: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ram_strobe  = strobe_q;
   assign bus.ram_rw      = rw_q;
   assign bus.ram_addr    = {addr_q[31:2], 2'b00};
   assign bus.ram_be      = be_q;
   assign bus.ram_wdata   = wdata_q;
   assign bus.rdata       = rdata_q;
   assign bus.done        = done_q;
   assign bus.err_align   = err_align_q;
   assign bus.err_timeout = err_timeout_q;
   assign bus.stall       = ((state_q == S_IDLE) && bus.ram_enable) ||
                            (state_q == S_WAIT) || (state_q == S_ERR);
   assign state_o         = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl: expected bus and response entries are
// queued by the driver and consumed by a negedge monitor.
module tb_mem_access_ctrl;
  localparam int TO = 8;
  localparam logic [2:0] K_DONE  = 3'b100;
  localparam logic [2:0] K_ALIGN = 3'b010;
  localparam logic [2:0] K_TMO   = 3'b001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] state_dbg;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .state_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [34:0] exp_resp_q[$];
  logic [68:0] exp_bus_q[$];
  int n_vec = 0;
  int n_err = 0;
  int stall_cnt = 0;
  int strobe_cnt = 0;
  logic strobe_prev = 1'b0;
  logic [68:0] eb;
  logic [34:0] er;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.stall) stall_cnt++;
      if (bus.ram_strobe) strobe_cnt++;
      if (bus.ram_strobe && !strobe_prev) begin
        if (exp_bus_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
        else begin
          eb = exp_bus_q.pop_front();
          check("ram_rw",    {31'd0, bus.ram_rw}, {31'd0, eb[68]});
          check("ram_be",    {28'd0, bus.ram_be}, {28'd0, eb[67:64]});
          check("ram_addr",  bus.ram_addr, eb[63:32]);
          check("ram_wdata", bus.ram_wdata, eb[31:0]);
        end
      end
      if (bus.done || bus.err_align || bus.err_timeout) begin
        if (exp_resp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
        else begin
          er = exp_resp_q.pop_front();
          check("resp_kind", {29'd0, bus.done, bus.err_align, bus.err_timeout}, {29'd0, er[34:32]});
          check("rdata", bus.rdata, er[31:0]);
        end
      end
    end
    strobe_prev = bus.ram_strobe;
  end

  // driver
  task automatic access(input logic [4:0] f, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input int moc_dly, input logic [31:0] rd,
                        input logic [2:0] kind, input logic [3:0] be,
                        input logic [31:0] ew, input logic [31:0] erd);
    @(posedge clk); #1;
    bus.ram_enable = 1'b1;
    bus.mem_fnc    = f;
    bus.rw         = r;
    bus.addr       = a;
    bus.wdata      = wd;
    if (kind != K_ALIGN) exp_bus_q.push_back({r, be, a[31:2], 2'b00, ew});
    exp_resp_q.push_back({kind, erd});
    @(posedge clk); #1;
    bus.ram_enable = 1'b0;
    bus.addr       = $urandom;
    bus.wdata      = $urandom;
    if (kind == K_DONE) begin
      repeat (moc_dly - 1) @(posedge clk);
      #1;
      bus.moc       = 1'b1;
      bus.ram_rdata = rd;
      @(posedge clk); #1;
      bus.moc       = 1'b0;
      bus.ram_rdata = $urandom;
      repeat (2) @(posedge clk);
    end else if (kind == K_TMO) begin
      repeat (TO + 2) @(posedge clk);
    end else begin
      repeat (2) @(posedge clk);
    end
  endtask

  int s0, t0;

  initial begin
    bus.ram_enable = 1'b0;
    bus.rw         = 1'b0;
    bus.mem_fnc    = 5'd0;
    bus.addr       = 32'd0;
    bus.wdata      = 32'd0;
    bus.moc        = 1'b0;
    bus.ram_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobe", {31'd0, bus.ram_strobe}, 32'd0);
    check("rst_stall",  {31'd0, bus.stall}, 32'd0);
    check("rst_rdata",  bus.rdata, 32'd0);
    check("rst_state",  {30'd0, state_dbg}, 32'd0);
    reset_n = 1'b1;

    s0 = stall_cnt; t0 = strobe_cnt;
    access(5'b01101, 1'b0, 32'h100, 32'hDEADBEEF, 3, 32'h0, K_DONE, 4'b1111, 32'hDEADBEEF, 32'h0);
    check("sw_stall_cycles",  stall_cnt - s0, 32'd4);
    check("sw_strobe_cycles", strobe_cnt - t0, 32'd3);

    access(5'b01010, 1'b1, 32'h203, 32'h0, 1, 32'h123456F0, K_DONE, 4'b0001, 32'h0, 32'hFFFFFFF0);
    access(5'b01100, 1'b1, 32'h203, 32'h0, 2, 32'h123456F0, K_DONE, 4'b0001, 32'h0, 32'h000000F0);
    access(5'b01011, 1'b1, 32'h202, 32'h0, 1, 32'h1234ABCD, K_DONE, 4'b0011, 32'h0, 32'hFFFFABCD);
    access(5'b01001, 1'b1, 32'h202, 32'h0, 1, 32'h1234ABCD, K_DONE, 4'b0011, 32'h0, 32'h0000ABCD);
    access(5'b01000, 1'b1, 32'h204, 32'h0, 2, 32'hCAFEF00D, K_DONE, 4'b1111, 32'h0, 32'hCAFEF00D);
    access(5'b01010, 1'b1, 32'h200, 32'h0, 1, 32'h80345678, K_DONE, 4'b1000, 32'h0, 32'hFFFFFF80);
    access(5'b01110, 1'b0, 32'h100, 32'h1234BEEF, 1, 32'h0, K_DONE, 4'b1100, 32'hBEEFBEEF, 32'hFFFFFF80);

    s0 = stall_cnt; t0 = strobe_cnt;
    access(5'b01110, 1'b0, 32'h101, 32'h1234, 0, 32'h0, K_ALIGN, 4'b0, 32'h0, 32'hFFFFFF80);
    check("align_strobe_cycles", strobe_cnt - t0, 32'd0);
    check("align_stall_cycles",  stall_cnt - s0, 32'd2);
    check("align_stall_release", {31'd0, bus.stall}, 32'd0);
    access(5'b00011, 1'b1, 32'h100, 32'h0, 0, 32'h0, K_ALIGN, 4'b0, 32'h0, 32'hFFFFFF80);
    access(5'b01000, 1'b1, 32'h102, 32'h0, 0, 32'h0, K_ALIGN, 4'b0, 32'h0, 32'hFFFFFF80);

    t0 = strobe_cnt;
    access(5'b01000, 1'b1, 32'h300, 32'h0, 0, 32'h0, K_TMO, 4'b1111, 32'h0, 32'hFFFFFF80);
    check("tmo_strobe_cycles", strobe_cnt - t0, TO);

    // moc outside WAIT must be ignored
    @(posedge clk); #1; bus.moc = 1'b1;
    repeat (3) @(posedge clk);
    #1; bus.moc = 1'b0;
    check("idle_moc_state", {30'd0, state_dbg}, 32'd0);

    // reset mid-access
    @(posedge clk); #1;
    bus.ram_enable = 1'b1; bus.mem_fnc = 5'b01000; bus.rw = 1'b1; bus.addr = 32'h400; bus.wdata = 32'h0;
    exp_bus_q.push_back({1'b1, 4'b1111, 32'h400, 32'h0});
    @(posedge clk); #1; bus.ram_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    check("mid_rst_strobe", {31'd0, bus.ram_strobe}, 32'd0);
    check("mid_rst_stall",  {31'd0, bus.stall}, 32'd0);
    check("mid_rst_rdata",  bus.rdata, 32'd0);
    check("mid_rst_be",     {28'd0, bus.ram_be}, 32'd0);
    check("mid_rst_addr",   bus.ram_addr, 32'd0);
    check("mid_rst_state",  {30'd0, state_dbg}, 32'd0);
    @(posedge clk); #1; reset_n = 1'b1;

    access(5'b01111, 1'b0, 32'h2, 32'h55, 1, 32'h0, K_DONE, 4'b0010, 32'h55555555, 32'h0);

    repeat (3) @(posedge clk);
    check("resp_q_drained", exp_resp_q.size(), 32'd0);
    check("bus_q_drained",  exp_bus_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Data-memory access sequencer sitting directly downstream of the main control decoder. It consumes RAMEnable, RW and the memory function code, then drives the RAM bus: strobe, byte enables, lane-aligned write data. It waits for MOC (memory operation complete), returns sign- or zero-extended load data, and stalls the datapath until the access completes, faults or times out.

Parameters:
TIMEOUT, 255, max cycles in WAIT without moc before abort (1..65535)
CNT_W, 16, width of timeout counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ram_enable  in  1  RAMEnable from control: memory op requested
rw  in  1  1=read (load), 0=write (store)
mem_fnc  in  5  01000 LW, 01001 LHU, 01010 LB, 01011 LH, 01100 LBU, 01101 SW, 01110 SH, 01111 SB
addr  in  32  effective address from ALU
wdata  in  32  store data (rt)
moc  in  1  memory operation complete from RAM
ram_rdata  in  32  RAM read bus
ram_strobe  out  1  MOV: access in progress to RAM
ram_rw  out  1  registered copy of rw
ram_addr  out  32  word address ({addr[31:2],2'b00})
ram_be  out  4  byte enables, big-endian (be[3] = bits 31:24 = byte offset 0)
ram_wdata  out  32  lane-replicated store data
rdata  out  32  extended load result, held until next completed load
stall  out  1  freeze PC/pipeline
done  out  1  1-cycle pulse on successful completion
err_align  out  1  1-cycle pulse on misaligned request
err_timeout  out  1  1-cycle pulse on timeout abort

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, counter 0. Strobe drops immediately, even mid-access.
- States: IDLE, WAIT, DONE, ERR.
- IDLE: on ram_enable=1, decode mem_fnc and capture addr, wdata, rw and mem_fnc into registers.
  - Legal code and aligned -> WAIT, ram_strobe=1 on next edge.
  - Misaligned (word with addr[1:0]!=0; half with addr[0]!=0) or code outside the list -> ERR. No strobe is issued.
  - ram_enable=0 -> stay in IDLE.
- stall is combinational: 1 when (IDLE and ram_enable), or WAIT, or ERR. 0 in DONE and in idle IDLE.
- WAIT:
  - ram_strobe, ram_addr, ram_be, ram_wdata and ram_rw are held stable.
  - Counter increments each cycle.
  - moc=1 -> latch ram_rdata (loads only), ram_strobe=0, go to DONE.
  - Counter==TIMEOUT with moc=0 -> ram_strobe=0, err_timeout=1 for one cycle, go to IDLE.
  - moc and timeout in the same cycle: moc wins.
- DONE: done=1 for one cycle, stall=0, counter cleared, go to IDLE. An IDLE with ram_enable still high starts a new access; the pipeline must have advanced.
- ERR: err_align or illegal-code path pulses err_align=1 for one cycle, done=0, go to IDLE.
- Minimum latency: request at edge N, strobe at N+1, moc at N+1 gives done at N+2.
- Byte enables:
  - Word: be=1111.
  - Half: be=1100 if addr[1]=0, else 0011.
  - Byte: be=1000>>addr[1:0].
- Store data: SH replicates wdata[15:0] into both halves; SB replicates wdata[7:0] into all four bytes; SW passes through.
- Load extract: byte/half selected by addr[1:0] in big-endian lanes.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - rdata updates only on a completed load; stores leave it unchanged.
- moc while not in WAIT is ignored.

Optional Feature:
MOC_SYNC_EN: when defined, moc passes through a 2-flop synchronizer (reset to 0) before use. Completion is seen 2 cycles later, so minimum latency is edge N+4, and the timeout counter counts the extra cycles. When undefined, moc is used directly, as described in Behaviour.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, moc 3 cycles after strobe -> be=1111, ram_wdata=0xDEADBEEF, stall high 4 cycles, done pulse once.
- LB addr=0x203, ram_rdata=0x123456F0 -> rdata=0xFFFFFFF0; same with LBU -> 0x000000F0.
- LH addr=0x202, ram_rdata=0x1234ABCD -> be=0011, rdata=0xFFFFABCD; LHU -> 0x0000ABCD.
- SH addr=0x101 -> err_align pulse, ram_strobe never asserted, done=0, stall released after ERR.
- TIMEOUT=8, LW, moc held 0 -> strobe drops after 8 WAIT cycles, err_timeout pulse, rdata unchanged.
- reset_n low during WAIT -> ram_strobe, stall and all outputs 0 asynchronously; after release, SB addr=0x2 wdata=0x55 -> be=0010, ram_wdata=0x55555555.
